telemetry_framer: RTL

//  Parametrised successor to the top-level angle/UART sweeper.
//  - Latches the latest sample from NUM_CH mic channels.
//  - Once every PERIOD cycles, snapshots the angle plus all channel samples.
//  - Sends them as one framed, checksummed byte packet through the existing

---
 rtl/telemetry_framer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/telemetry_framer.sv
// Periodically snapshots angle + latest channel samples and streams them as a checksummed byte frame to a UART.
// Latency: frame starts on the edge where the period counter wraps; backpressure is tx_busy, one uart_rdy per byte.
module telemetry_framer #(
    parameter int          NUM_CH   = 2,
    parameter int          SAMPLE_W = 18,
    parameter int          PERIOD   = 100_000_000,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]                ch_rdy,
    input  logic [7:0]                       angle,
    input  logic                             tx_busy,
    output logic [7:0]                       uart_data,
    output logic                             uart_rdy,
    output logic                             frame_active,
    output logic [15:0]                      frame_count,
    output logic                             overrun
);

    localparam int BPC = (SAMPLE_W + 7) / 8;
    localparam int L   = 4 + NUM_CH * BPC;
    localparam int CW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IW  = $clog2(L);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                             state_q, state_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    lat_q;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic [L-1:0][7:0]                  frame_q, frame_d, snap_d;
    logic [15:0]                        fcnt_q, fcnt_d, fcnt_inc;
    logic                               ovr_q, ovr_d;
    logic                               tick;
    logic [8*BPC-1:0]                   ext;
    logic [7:0]                         csum;

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_rdy[i]) lat_q[i] <= ch_data[i];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!enable)                        cnt_d = '0;
        else if (cnt_q == CW'(PERIOD - 1))  cnt_d = '0;
        else                                cnt_d = cnt_q + CW'(1);
    end

    assign tick     = enable && (cnt_q == CW'(PERIOD - 1));
    assign fcnt_inc = fcnt_q + 16'd1;

    // Frame image built from pre-edge latch values so a coincident ch_rdy lands in the next frame.
    always_comb begin
        snap_d    = '0;
        ext       = '0;
        csum      = '0;
        snap_d[0] = HEADER;
        snap_d[1] = fcnt_inc[7:0];
        snap_d[2] = angle;
        for (int c = 0; c < NUM_CH; c++) begin
            ext = (8*BPC)'(lat_q[c]);
            for (int b = 0; b < BPC; b++) begin
                snap_d[3 + c*BPC + b] = ext[8*(BPC-1-b) +: 8];
            end
        end
        for (int k = 1; k < L - 1; k++) begin
            csum = csum + snap_d[k];
        end
        snap_d[L-1] = csum;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        fcnt_d   = fcnt_q;
        ovr_d    = ovr_q;
        uart_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    frame_d = snap_d;
                    fcnt_d  = fcnt_inc;
                end
            end
            LOAD:      state_d = STROBE;
            STROBE: begin
                if (!tx_busy) begin
                    uart_rdy = 1'b1;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == IW'(L - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = LOAD;
                    end
                end
            end
            default:   state_d = IDLE;
        endcase
        if (tick && (state_q != IDLE)) ovr_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            fcnt_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            fcnt_q  <= fcnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign uart_data    = (state_q == IDLE) ? 8'h00 : frame_q[idx_q];
    assign frame_active = (state_q != IDLE);
    assign frame_count  = fcnt_q;
    assign overrun      = ovr_q;

endmodule
